// File: rtl/dmem_ctrl_if.sv
// Request/response bundle between the CPU datapath and the data-memory controller.
// The master side is the CPU; the slave side is the controller.
interface dmem_ctrl_if;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        access_fault;
    logic        fault_sticky;

    modport master (
        output req_valid, req_we, funct3, addr, wdata,
        input  rdata, stall, access_fault, fault_sticky
    );

    modport slave (
        input  req_valid, req_we, funct3, addr, wdata,
        output rdata, stall, access_fault, fault_sticky
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: word-organised synchronous RAM with byte-lane stores,
// right-justified zero-filled loads, and rejection of misaligned/illegal requests.
module dmem_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        reset,
    dmem_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RD, ACK} state_t;

    state_t            state;
    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic [31:0]       word_q;
    logic [31:0]       rdata_q;
    logic              sticky_q;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        off;
    logic              legal;
    logic              take;
    logic              wr_en;
    logic              rd_en;
    logic [3:0]        be;
    logic [31:0]       wlanes;
    logic              unused_addr;

    function automatic logic is_legal(input logic we, input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b000:  is_legal = 1'b1;
            3'b001:  is_legal = !a[0];
            3'b010:  is_legal = (a == 2'b00);
            3'b100:  is_legal = !we;
            3'b101:  is_legal = !we && !a[0];
            default: is_legal = 1'b0;
        endcase
    endfunction

    // Shift the addressed lane down to bit 0 and clear everything above the access size.
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] a,
                                            input logic [1:0] sz);
        logic [31:0] s;
        s = w >> {a, 3'b000};
        case (sz)
            2'b00:   extract = {24'h0, s[7:0]};
            2'b01:   extract = {16'h0, s[15:0]};
            default: extract = s;
        endcase
    endfunction

    assign idx         = bus.addr[ADDR_W+1:2];
    assign off         = bus.addr[1:0];
    assign unused_addr = ^{bus.addr[31:ADDR_W+2]};
    assign legal       = is_legal(bus.req_we, bus.funct3, off);
    assign take        = (state == IDLE) && bus.req_valid;
    assign wr_en       = take && legal && bus.req_we && !reset;
    assign rd_en       = take && legal && !bus.req_we;
    assign wlanes      = bus.wdata << {off, 3'b000};

    always_comb begin
        be = 4'b1111;
        case (bus.funct3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
    end

    assign bus.access_fault = take && !legal;
    assign bus.stall        = (take && legal) || (state == RD);
    assign bus.rdata        = rdata_q;
    assign bus.fault_sticky = sticky_q;

    // RAM stage: byte-enabled write or registered word read, issued from IDLE.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en && be[i]) begin
                mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
        if (rd_en) begin
            word_q <= mem[idx];
        end
    end

    // Control stage: access sequencing and the load result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rdata_q  <= 32'h0;
            sticky_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (!legal) begin
                            sticky_q <= 1'b1;
                        end else if (bus.req_we) begin
                            state <= ACK;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    rdata_q <= extract(word_q, off, bus.funct3[1:0]);
                    state   <= ACK;
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized scoreboard bench for dmem_ctrl against a byte-addressed memory model.
module tb_dmem_ctrl;
    localparam int ADDR_W    = 10;
    localparam int MEM_BYTES = 4 << ADDR_W;

    logic clk = 1'b0;
    logic reset;

    dmem_ctrl_if bus();

    dmem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fault;
        int          stalls;
        logic [31:0] rdata;
        logic        sticky;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  ref_mem [MEM_BYTES];
    logic [31:0] ref_rdata;
    logic        ref_sticky;
    int          n_vec;
    int          n_bad;
    bit          mon_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model a request from the access rules, queue its expected completion, then drive it
    // like a CPU that stays frozen while stall is high.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        exp_t e;
        int   size;
        int   base;
        bit   ok;
        bit   done;
        size = 1 << f3[1:0];
        base = int'(a % MEM_BYTES);
        ok   = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && !(we && f3[2]) && (a % size == 0);
        e.fault  = !ok;
        e.sticky = ref_sticky;
        if (!ok) begin
            e.stalls   = 0;
            ref_sticky = 1'b1;
        end else if (we) begin
            e.stalls = 1;
            for (int b = 0; b < size; b++) ref_mem[base+b] = wd[8*b +: 8];
        end else begin
            e.stalls  = 2;
            ref_rdata = 32'h0;
            for (int b = 0; b < size; b++) ref_rdata |= 32'(ref_mem[base+b]) << (8*b);
        end
        e.rdata = ref_rdata;

        @(negedge clk);
        sb.push_back(e);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.funct3    = f3;
        bus.addr      = a;
        bus.wdata     = wd;
        done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (!bus.stall) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL stall_timeout: stall still 1 after 6 cycles, expected release (addr %h)", a);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // Monitor: every cycle ending a request (valid with stall low) pops one expectation.
    initial begin
        int   cnt;
        exp_t e;
        cnt = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!mon_en || reset) begin
                cnt = 0;
            end else if (!bus.req_valid) begin
                check("idle_stall", 32'(bus.stall), 32'h0);
                cnt = 0;
            end else if (bus.stall) begin
                cnt++;
            end else begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_completion: got completion, expected none queued");
                end else begin
                    e = sb.pop_front();
                    check("access_fault", 32'(bus.access_fault), 32'(e.fault));
                    check("stall_cycles", 32'(cnt), 32'(e.stalls));
                    check("rdata", bus.rdata, e.rdata);
                    check("fault_sticky", 32'(bus.fault_sticky), 32'(e.sticky));
                end
                cnt = 0;
            end
        end
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        logic [2:0]  legal_f3 [5];
        legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        reset         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.funct3    = 3'd0;
        bus.addr      = 32'h0;
        bus.wdata     = 32'h0;
        mon_en        = 1'b0;
        ref_sticky    = 1'b0;
        ref_rdata     = 32'h0;
        n_vec         = 0;
        n_bad         = 0;

        // Asynchronous reset asserted between clock edges.
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("reset_stall", 32'(bus.stall), 32'h0);
        check("reset_rdata", bus.rdata, 32'h0);
        check("reset_sticky", 32'(bus.fault_sticky), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("idle_after_reset", 32'(bus.stall), 32'h0);
        mon_en = 1'b1;

        for (int w = 0; w < 16; w++) issue(1'b1, 3'd2, 32'(w * 4), $urandom);

        issue(1'b1, 3'd2, 32'h10, 32'h1122_3344);
        issue(1'b1, 3'd0, 32'h13, 32'h0000_00AA);
        issue(1'b0, 3'd4, 32'h13, 32'h0);
        issue(1'b0, 3'd5, 32'h12, 32'h0);
        issue(1'b0, 3'd2, 32'h10, 32'h0);
        issue(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF);
        issue(1'b0, 3'd2, 32'h10, 32'h0);
        issue(1'b0, 3'd2, 32'h1010, 32'h0);
        issue(1'b0, 3'd2, 32'h06, 32'h0);
        issue(1'b1, 3'd1, 32'h03, 32'h1234_5678);
        issue(1'b0, 3'd3, 32'h00, 32'h0);
        issue(1'b0, 3'd2, 32'h04, 32'h0);
        idle();

        for (int n = 0; n < 300; n++) begin
            f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7))
                                             : legal_f3[$urandom_range(0, 4)];
            a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) a = a & ~32'((1 << f3[1:0]) - 1);
            issue(1'($urandom_range(0, 1)), f3, a, $urandom);
            if ($urandom_range(0, 3) == 0) idle();
        end

        issue(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF);
        issue(1'b0, 3'd2, 32'h10, 32'h0);
        idle();
        #3;
        mon_en = 1'b0;

        // Reset while a load sits in RD.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.funct3    = 3'd2;
        bus.addr      = 32'h10;
        @(negedge clk);
        #1;
        check("rd_stall", 32'(bus.stall), 32'h1);
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        #1;
        check("rd_reset_rdata", bus.rdata, 32'h0);
        check("rd_reset_stall", 32'(bus.stall), 32'h0);
        check("rd_reset_sticky", 32'(bus.fault_sticky), 32'h0);
        @(negedge clk);
        reset      = 1'b0;
        ref_rdata  = 32'h0;
        ref_sticky = 1'b0;
        mon_en     = 1'b1;
        issue(1'b0, 3'd2, 32'h10, 32'h0);
        issue(1'b0, 3'd2, 32'h1010, 32'h0);
        idle();
        repeat (3) @(negedge clk);

        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller for the RISC-V CPU, downstream of the datapath's memory address/data outputs and upstream of its load-extension logic. It owns a word-organised synchronous data RAM and turns each load/store request into a multi-cycle access, holding the CPU with `stall`. Stores write the SB/SH/SW byte lanes selected by the address. Loads return the addressed byte/halfword/word right-justified and zero-filled, and the datapath then applies the sign/zero extension. Misaligned or illegal-width requests are rejected and recorded.

## Interface
Parameters:
- `ADDR_W`, 10: word-address width; RAM holds 2^ADDR_W 32-bit words (4 KiB default).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: memory instruction present (load or store).
- `req_we` in 1: 1 = store, 0 = load.
- `funct3` in 3: Instr[14:12]; 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr` in 32: byte address (datapath ALU result).
- `wdata` in 32: store data; SB uses [7:0], SH uses [15:0].
- `rdata` out 32: load result, right-justified, upper bits zero.
- `stall` out 1: CPU must hold PC and suppress register write-back.
- `access_fault` out 1: combinational; current request rejected.
- `fault_sticky` out 1: set by any fault, cleared only by reset.

## Operation
- Word index = addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses alias.
- Legality:
  - funct3 011/110/111 is illegal.
  - H/HU is illegal when addr[0]=1.
  - W is illegal when addr[1:0]≠0.
  - SB/SH/SW use funct3 000/001/010 only; a store with funct3 1xx is illegal.
- States: IDLE, RD, ACK.
- IDLE:
  - req_valid=0: stay in IDLE, stall=0.
  - req_valid=1 and illegal: access_fault=1, stall=0, no RAM access, fault_sticky set at the edge, stay in IDLE.
  - Legal store: stall=1. The RAM write is committed at the edge with byte enables:
    - B: 0001<<addr[1:0]
    - H: 0011<<addr[1:0]
    - W: 1111
    - wdata lanes are shifted left by 8·addr[1:0].
    - Next state ACK.
  - Legal load: stall=1, RAM read issued (registered), next state RD.
- RD: stall=1. The RAM word is shifted right by 8·addr[1:0] and masked to 8/16/32 bits per funct3[1:0]. The result is registered into `rdata`. Next state ACK.
- ACK: stall=0 and the CPU advances this cycle. `rdata` is valid and stable. Next state IDLE unconditionally, and the still-asserted request is not re-issued.
- `rdata` holds its last value outside ACK.
- Inputs are assumed stable while stall=1 (the CPU is frozen). The controller samples them combinationally in IDLE and RD; it does not latch them.
- RAM contents are not reset and initialise as X (a bench may preload them).

## Timing
- Store: 2 cycles (IDLE+ACK); the write is visible to a load issued in the next instruction.
- Load: 3 cycles (IDLE, RD, ACK); data is valid in the ACK cycle.
- Faulting access: 1 cycle, stall=0.
- Back-to-back memory instructions: a new request is accepted in the IDLE cycle immediately after ACK.
- Reset values:
  - state=IDLE
  - rdata=0
  - stall=0 (IDLE with req_valid=0)
  - fault_sticky=0
  - access_fault follows the inputs.
- Reset during RD or ACK: the FSM returns to IDLE immediately and rdata=0. A store committed at an earlier edge stays written, and no partial write occurs.
- req_valid dropping during RD: the FSM still completes RD→ACK→IDLE; the CPU guarantees this does not happen.

## Test plan
- Reset then idle: reset=1 mid-cycle → stall=0, rdata=0, fault_sticky=0 asynchronously; with req_valid=0 the FSM stays in IDLE.
- SW then LW: SW 0xDEADBEEF @0x10 → stall=1 for 1 cycle. LW @0x10 → stall high 2 cycles, rdata=0xDEADBEEF in the ACK cycle.
- Byte lanes: SB wdata=0x000000AA @0x13 onto word 0x11223344 → word becomes 0xAA223344. LBU @0x13 → rdata=0x000000AA. LHU @0x12 → 0x0000AA22.
- Misalignment: LW @0x06 → access_fault=1, stall=0, RAM unchanged, fault_sticky=1 until reset. SH @0x03 → same response.
- Illegal funct3 011 load @0x0 → fault with no access. Aliasing: with ADDR_W=10, LW @0x1010 reads the same word as @0x10.
- Reset in RD: assert reset during RD of LW @0x10 → state IDLE and rdata=0 immediately. The following LW @0x10 still returns 0xDEADBEEF.
